// File: rtl/sprite_mem_pkg.sv
// Shared constants and types for the sprite ROM access path.
//   SPRITE_ADDR_W / SPRITE_DATA_W : geometry of the on-chip sprite ROM
//   REQ_*                         : fixed requester slot assignment
//   tag_t                         : entry of the read-return tag pipeline
package sprite_mem_pkg;

    localparam int unsigned SPRITE_ADDR_W = 18;
    localparam int unsigned SPRITE_DATA_W = 8;

    localparam int unsigned REQ_BG      = 0;
    localparam int unsigned REQ_FIREBOY = 1;
    localparam int unsigned REQ_ICEGIRL = 2;
    localparam int unsigned REQ_MISC    = 3;

    // Wide enough for up to 8 requesters.
    localparam int unsigned TAG_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Bus bundle between the sprite renderers, the arbiter and the sprite ROM.
//   req/req_addr      : per-requester read request and packed word address
//   gnt               : one-hot grant (ready), combinational from req
//   rvalid/rdata      : one-hot return strobe, broadcast pixel byte
//   rom_addr/rom_rd   : registered ROM address and read enable
//   rom_q             : ROM output data
// Modports:
//   master : the environment side (renderers plus the ROM itself)
//   slave  : the arbiter
interface sprite_rom_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned DATA_W  = 8
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         rom_addr;
    logic                      rom_rd;
    logic [DATA_W-1:0]         rom_q;

    modport master (
        output req, req_addr, rom_q,
        input  gnt, rvalid, rdata, rom_addr, rom_rd
    );

    modport slave (
        input  req, req_addr, rom_q,
        output gnt, rvalid, rdata, rom_addr, rom_rd
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority selector.
//   req_i : request vector
//   ptr_i : index with highest priority this cycle (must be < N)
//   gnt_o : one-hot grant to the first request at or above ptr_i,
//           wrapping modulo N; zero when no request is present
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] gnt_dbl;
    logic           found;

    // Rotate so ptr_i lands at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        rot_req = N'({req_i, req_i} >> ptr_i);
        rot_gnt = '0;
        found   = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (rot_req[j] && !found) begin
                rot_gnt[j] = 1'b1;
                found      = 1'b1;
            end
        end
        gnt_dbl = {{N{1'b0}}, rot_gnt} << ptr_i;
        gnt_o   = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares the single sprite ROM read port among the per-frame renderers.
// One requester is granted per cycle in round-robin order; its address is
// registered onto the ROM port the following cycle and a tag travels down a
// ROM_LAT+1 deep pipeline so the returned byte is steered back to the right
// requester ROM_LAT+2 cycles after the grant.
// Ports:
//   Clk         : pixel clock
//   Reset_n     : asynchronous active-low reset
//   frame_start : one-cycle vblank pulse, restarts round-robin at index 0
//   bus         : requester/ROM bundle (slave side)
module sprite_rom_arbiter
    import sprite_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = SPRITE_ADDR_W,
    parameter int unsigned DATA_W  = SPRITE_DATA_W,
    parameter int unsigned ROM_LAT = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_start,
    sprite_rom_arbiter_if.slave  bus
);

    localparam int unsigned PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DEPTH = ROM_LAT + 1;

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               rom_rd_q, rom_rd_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    tag_t               tag_q [DEPTH];
    tag_t               tag_d;
    tag_t               tag_last;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic               grant_any;
    logic [PW-1:0]      grant_idx;
    logic [ADDR_W-1:0]  grant_addr;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req_i (bus.req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt)
    );

    // gnt is combinational, so it is masked while reset is held to keep the
    // renderers from seeing a handshake the datapath cannot accept.
    always_comb begin
        gnt        = Reset_n ? arb_gnt : '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                grant_any  = 1'b1;
                grant_idx  = PW'(i);
                grant_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign tag_last = tag_q[DEPTH-1];

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rom_addr_d = rom_addr_q;
        rom_rd_d   = grant_any;
        rdata_d    = rdata_q;
        rvalid_d   = '0;

        // frame_start takes precedence over the post-grant pointer advance;
        // the grant in the same cycle still proceeds through the pipeline.
        if (frame_start) begin
            rr_ptr_d = '0;
        end else if (grant_any) begin
            rr_ptr_d = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end

        if (grant_any) begin
            rom_addr_d = grant_addr;
        end

        tag_d.valid = grant_any;
        tag_d.idx   = TAG_IDX_W'(grant_idx);

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rvalid_d[i] = tag_last.valid && (tag_last.idx == TAG_IDX_W'(i));
        end
        if (tag_last.valid) begin
            rdata_d = bus.rom_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr_q   <= '0;
            rom_addr_q <= '0;
            rom_rd_q   <= 1'b0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rom_addr_q <= rom_addr_d;
            rom_rd_q   <= rom_rd_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            tag_q[0]   <= tag_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_rd   = rom_rd_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed self-checking bench for sprite_rom_arbiter.
// The ROM model is two registered stages returning addr[7:0] ^ 8'h6E, so
// address 18'h01234 reads back 8'h5A.
module tb_sprite_rom_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 18;
    localparam int unsigned DW   = 8;
    localparam int unsigned LAT  = 2;

    logic Clk = 1'b0;
    logic Reset_n;
    logic frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] addr [NREQ];
    logic [7:0]    rom_a1;

    sprite_rom_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ (NREQ),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_LAT (LAT)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .bus         (bus.slave)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        rom_a1    <= bus.rom_addr[7:0];
        bus.rom_q <= rom_a1 ^ 8'h6E;
    end

    function automatic logic [7:0] rom_data(input logic [7:0] a);
        return a ^ 8'h6E;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pack_addrs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW] = addr[i];
        end
    endtask

    task automatic test_reset();
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        addr[0] = 18'h20010; addr[1] = 18'h31021;
        addr[2] = 18'h01234; addr[3] = 18'h3F043;
        pack_addrs();
        bus.req = 4'b1111;
        repeat (3) tick();
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected %b", bus.gnt, 4'b0000); end
        n_checks++;
        if (bus.rom_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rom_rd: got %b expected 0", bus.rom_rd); end
        n_checks++;
        if (bus.rvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0000", bus.rvalid); end
        n_checks++;
        if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", bus.rdata); end
        n_checks++;
        if (bus.rom_addr !== 18'h0) begin n_fail++; $display("FAIL reset_rom_addr: got %h expected 0", bus.rom_addr); end
        Reset_n = 1'b1;
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b expected 0001", bus.gnt); end
        bus.req = 4'b0000;
        repeat (6) tick();
    endtask

    task automatic test_single();
        logic [3:0] exp_gnt;
        logic [3:0] exp_rv;
        bus.req = 4'b0100;
        for (int c = 0; c < 9; c++) begin
            if (c == 3) bus.req = 4'b0000;
            #1;
            exp_gnt = (c < 3) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL single_gnt c%0d: got %b expected %b", c, bus.gnt, exp_gnt); end
            n_checks++;
            if (bus.rom_rd !== (c >= 1 && c <= 3)) begin n_fail++; $display("FAIL single_rom_rd c%0d: got %b", c, bus.rom_rd); end
            if (c >= 1) begin
                n_checks++;
                if (bus.rom_addr !== 18'h01234) begin n_fail++; $display("FAIL single_rom_addr c%0d: got %h expected 01234", c, bus.rom_addr); end
            end
            exp_rv = (c >= 4 && c <= 6) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (bus.rvalid !== exp_rv) begin n_fail++; $display("FAIL single_rvalid c%0d: got %b expected %b", c, bus.rvalid, exp_rv); end
            if (c >= 4) begin
                n_checks++;
                if (bus.rdata !== 8'h5A) begin n_fail++; $display("FAIL single_rdata c%0d: got %h expected 5a", c, bus.rdata); end
            end
            tick();
        end
    endtask

    task automatic test_full_contention();
        logic [3:0] exp_gnt;
        logic [3:0] exp_rv;
        int         gcount [NREQ];
        int         k;
        for (int i = 0; i < NREQ; i++) gcount[i] = 0;
        frame_start = 1'b1;
        bus.req     = 4'b0000;
        tick();
        frame_start = 1'b0;
        for (int c = 0; c < 18; c++) begin
            bus.req = (c < 12) ? 4'b1111 : 4'b0000;
            #1;
            exp_gnt = (c < 12) ? (4'b0001 << (c % 4)) : 4'b0000;
            n_checks++;
            if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL full_gnt c%0d: got %b expected %b", c, bus.gnt, exp_gnt); end
            for (int i = 0; i < NREQ; i++) if (bus.gnt[i] === 1'b1) gcount[i]++;
            if (c >= 1 && c <= 12) begin
                k = (c - 1) % 4;
                n_checks++;
                if (bus.rom_addr !== addr[k]) begin n_fail++; $display("FAIL full_rom_addr c%0d: got %h expected %h", c, bus.rom_addr, addr[k]); end
            end
            exp_rv = (c >= 4 && c <= 15) ? (4'b0001 << ((c - 4) % 4)) : 4'b0000;
            n_checks++;
            if (bus.rvalid !== exp_rv) begin n_fail++; $display("FAIL full_rvalid c%0d: got %b expected %b", c, bus.rvalid, exp_rv); end
            if (c >= 4 && c <= 15) begin
                k = (c - 4) % 4;
                n_checks++;
                if (bus.rdata !== rom_data(addr[k][7:0])) begin n_fail++; $display("FAIL full_rdata c%0d: got %h expected %h", c, bus.rdata, rom_data(addr[k][7:0])); end
            end
            tick();
        end
        for (int i = 0; i < NREQ; i++) begin
            n_checks++;
            if (gcount[i] != 3) begin n_fail++; $display("FAIL full_grant_count[%0d]: got %0d expected 3", i, gcount[i]); end
        end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001;
        // Grant index 2 alone so the pointer lands on 3.
        bus.req = 4'b0100;
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup_gnt: got %b expected 0100", bus.gnt); end
        tick();
        bus.req = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus.gnt !== exp_seq[c]) begin n_fail++; $display("FAIL wrap_gnt c%0d: got %b expected %b", c, bus.gnt, exp_seq[c]); end
            tick();
        end
        bus.req = 4'b0000;
        repeat (6) tick();
    endtask

    task automatic test_frame_start();
        logic [3:0] exp_gnt [4];
        logic [3:0] exp_rv  [9];
        exp_gnt[0] = 4'b0010; exp_gnt[1] = 4'b0100; exp_gnt[2] = 4'b0001; exp_gnt[3] = 4'b0000;
        for (int c = 0; c < 9; c++) exp_rv[c] = 4'b0000;
        exp_rv[4] = 4'b0010; exp_rv[5] = 4'b0100; exp_rv[6] = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            bus.req     = (c < 3) ? 4'b1111 : 4'b0000;
            frame_start = (c == 1);
            #1;
            if (c < 4) begin
                n_checks++;
                if (bus.gnt !== exp_gnt[c]) begin n_fail++; $display("FAIL fs_gnt c%0d: got %b expected %b", c, bus.gnt, exp_gnt[c]); end
            end
            n_checks++;
            if (bus.rvalid !== exp_rv[c]) begin n_fail++; $display("FAIL fs_rvalid c%0d: got %b expected %b", c, bus.rvalid, exp_rv[c]); end
            if (c == 5) begin
                n_checks++;
                if (bus.rdata !== rom_data(addr[2][7:0])) begin n_fail++; $display("FAIL fs_rdata: got %h expected %h", bus.rdata, rom_data(addr[2][7:0])); end
            end
            tick();
        end
        frame_start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_gnt [3];
        exp_gnt[0] = 4'b0010; exp_gnt[1] = 4'b0100; exp_gnt[2] = 4'b1000;
        bus.req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus.gnt !== exp_gnt[c]) begin n_fail++; $display("FAIL rmid_gnt c%0d: got %b expected %b", c, bus.gnt, exp_gnt[c]); end
            tick();
        end
        bus.req = 4'b0000;
        #1;
        n_checks++;
        if (bus.rvalid !== 4'b0000) begin n_fail++; $display("FAIL rmid_pre_rvalid: got %b expected 0000", bus.rvalid); end
        Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_checks++;
            if (bus.rvalid !== 4'b0000) begin n_fail++; $display("FAIL rmid_stale_rvalid c%0d: got %b expected 0000", c, bus.rvalid); end
            tick();
        end
        bus.req = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) bus.req = 4'b0000;
            #1;
            if (c == 0) begin
                n_checks++;
                if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL rmid_new_gnt: got %b expected 0001", bus.gnt); end
            end
            n_checks++;
            if (bus.rvalid !== ((c == 4) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL rmid_new_rvalid c%0d: got %b", c, bus.rvalid); end
            if (c == 4) begin
                n_checks++;
                if (bus.rdata !== rom_data(addr[0][7:0])) begin n_fail++; $display("FAIL rmid_new_rdata: got %h expected %h", bus.rdata, rom_data(addr[0][7:0])); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_contention();
        test_wrap_skip();
        test_frame_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
